operand_fetch: RTL and testbench

- Initiator side of the 8x8 register file. Drives its two read ports and its write port.
- Accepts decoded instructions (rs1, rs2, rd, op) over a valid/ready handshake and reads both operands.
- Keeps a per-register busy scoreboard, stalls on RAW/WAW hazards, and forwards same-cycle writeback data.
- Emits a registered operand bundle to the execute stage.

---
 rtl/operand_fetch_pkg.sv | 17 +
 rtl/operand_fetch_if.sv | 47 ++++
 rtl/operand_fetch_op_scoreboard.sv | 42 ++++
 rtl/operand_fetch.sv | 79 +++++++
 tb/tb_operand_fetch.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/operand_fetch_pkg.sv
// Shared widths and operand-bundle type for the operand fetch stage and the 8x8 register file.
package operand_fetch_pkg;
  localparam int DW   = 8;
  localparam int AW   = 3;
  localparam int NREG = 2 ** AW;
  localparam int OPW  = 4;

  typedef struct packed {
    logic [DW-1:0]  a;
    logic [DW-1:0]  b;
    logic [AW-1:0]  rd;
    logic           wr;
    logic [OPW-1:0] op;
  } bundle_t;

  localparam bundle_t BUNDLE_RST = '0;
endpackage

// File: rtl/operand_fetch_if.sv
// Decode, register-file, writeback and execute-side signals of the operand fetch stage.
interface operand_fetch_if import operand_fetch_pkg::*; ();
  logic           in_valid;
  logic           in_ready;
  logic [AW-1:0]  in_rs1;
  logic [AW-1:0]  in_rs2;
  logic           in_use_rs2;
  logic [AW-1:0]  in_rd;
  logic           in_wr;
  logic [OPW-1:0] in_op;

  logic [AW-1:0]  rf_raddr1;
  logic [AW-1:0]  rf_raddr2;
  logic [DW-1:0]  rf_rdata1;
  logic [DW-1:0]  rf_rdata2;
  logic           rf_wen;
  logic [AW-1:0]  rf_waddr;
  logic [DW-1:0]  rf_wdata;

  logic           wb_valid;
  logic [AW-1:0]  wb_addr;
  logic [DW-1:0]  wb_data;

  logic           out_valid;
  logic           out_ready;
  logic [DW-1:0]  out_a;
  logic [DW-1:0]  out_b;
  logic [AW-1:0]  out_rd;
  logic           out_wr;
  logic [OPW-1:0] out_op;

  // Environment side: decoder, register file, execute stage.
  modport master (
    output in_valid, in_rs1, in_rs2, in_use_rs2, in_rd, in_wr, in_op,
    output rf_rdata1, rf_rdata2, wb_valid, wb_addr, wb_data, out_ready,
    input  in_ready, rf_raddr1, rf_raddr2, rf_wen, rf_waddr, rf_wdata,
    input  out_valid, out_a, out_b, out_rd, out_wr, out_op
  );

  // Operand fetch side.
  modport slave (
    input  in_valid, in_rs1, in_rs2, in_use_rs2, in_rd, in_wr, in_op,
    input  rf_rdata1, rf_rdata2, wb_valid, wb_addr, wb_data, out_ready,
    output in_ready, rf_raddr1, rf_raddr2, rf_wen, rf_waddr, rf_wdata,
    output out_valid, out_a, out_b, out_rd, out_wr, out_op
  );
endinterface

// File: rtl/operand_fetch_op_scoreboard.sv
// Per-register busy flags with set/clear and three "busy and not being written back" lookups.
module op_scoreboard import operand_fetch_pkg::*; (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_set,
  input  logic [AW-1:0] i_set_addr,
  input  logic          i_clr,
  input  logic [AW-1:0] i_clr_addr,
  input  logic [AW-1:0] i_addr_a,
  input  logic [AW-1:0] i_addr_b,
  input  logic [AW-1:0] i_addr_c,
  output logic          o_hit_a,
  output logic          o_hit_b,
  output logic          o_hit_c
);
  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_clr_mask;
  logic [NREG-1:0] w_live;

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_busy
      assign w_clr_mask[gi] = i_clr && (i_clr_addr == AW'(gi));

      // Set takes priority so a new writer is tracked even if the old one retires now.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_busy[gi] <= 1'b0;
        end else if (i_set && (i_set_addr == AW'(gi))) begin
          r_busy[gi] <= 1'b1;
        end else if (w_clr_mask[gi]) begin
          r_busy[gi] <= 1'b0;
        end
      end
    end
  endgenerate

  assign w_live  = r_busy & ~w_clr_mask;
  assign o_hit_a = w_live[i_addr_a];
  assign o_hit_b = w_live[i_addr_b];
  assign o_hit_c = w_live[i_addr_c];
endmodule

// File: rtl/operand_fetch.sv
// Operand fetch: reads both sources, stalls on RAW/WAW via the busy scoreboard,
// forwards same-cycle writeback data and registers the operand bundle for execute.
module operand_fetch import operand_fetch_pkg::*; (
  input  logic          clk,
  input  logic          rst,
  operand_fetch_if.slave bus
);
  bundle_t r_out;
  logic    r_out_valid;

  logic    w_hit_rs1;
  logic    w_hit_rs2;
  logic    w_hit_rd;
  logic    w_hazard;
  logic    w_ready;
  logic    w_accept;
  logic    w_fwd_rs1;
  logic    w_fwd_rs2;
  bundle_t w_next;

  op_scoreboard u_sb (
    .clk        (clk),
    .rst        (rst),
    .i_set      (w_accept && bus.in_wr),
    .i_set_addr (bus.in_rd),
    .i_clr      (bus.wb_valid),
    .i_clr_addr (bus.wb_addr),
    .i_addr_a   (bus.in_rs1),
    .i_addr_b   (bus.in_rs2),
    .i_addr_c   (bus.in_rd),
    .o_hit_a    (w_hit_rs1),
    .o_hit_b    (w_hit_rs2),
    .o_hit_c    (w_hit_rd)
  );

  assign w_hazard = w_hit_rs1
                 || (bus.in_use_rs2 && w_hit_rs2)
                 || (bus.in_wr && w_hit_rd);
  assign w_ready  = (!r_out_valid || bus.out_ready) && !w_hazard;
  assign w_accept = bus.in_valid && w_ready;

  assign w_fwd_rs1 = bus.wb_valid && (bus.wb_addr == bus.in_rs1);
  assign w_fwd_rs2 = bus.wb_valid && (bus.wb_addr == bus.in_rs2);

  always_comb begin
    w_next    = BUNDLE_RST;
    w_next.a  = w_fwd_rs1 ? bus.wb_data : bus.rf_rdata1;
    w_next.b  = !bus.in_use_rs2 ? '0 : (w_fwd_rs2 ? bus.wb_data : bus.rf_rdata2);
    w_next.rd = bus.in_rd;
    w_next.wr = bus.in_wr;
    w_next.op = bus.in_op;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out       <= BUNDLE_RST;
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out       <= w_next;
      r_out_valid <= 1'b1;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_ready;
  assign bus.rf_raddr1 = bus.in_rs1;
  assign bus.rf_raddr2 = bus.in_rs2;
  assign bus.rf_wen    = bus.wb_valid;
  assign bus.rf_waddr  = bus.wb_addr;
  assign bus.rf_wdata  = bus.wb_data;

  assign bus.out_valid = r_out_valid;
  assign bus.out_a     = r_out.a;
  assign bus.out_b     = r_out.b;
  assign bus.out_rd    = r_out.rd;
  assign bus.out_wr    = r_out.wr;
  assign bus.out_op    = r_out.op;
endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a behavioural 8x8 register file on the rf_* port.
module tb_operand_fetch;
  import operand_fetch_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  operand_fetch_if bus ();

  operand_fetch dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [DW-1:0] rf_mem [NREG];
  always @(posedge clk) begin
    if (bus.rf_wen) rf_mem[bus.rf_waddr] <= bus.rf_wdata;
  end
  assign bus.rf_rdata1 = rf_mem[bus.rf_raddr1];
  assign bus.rf_rdata2 = rf_mem[bus.rf_raddr2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2, input logic use2,
                       input logic [AW-1:0] rd, input logic wr, input logic [OPW-1:0] op);
    bus.in_valid   = 1'b1;
    bus.in_rs1     = rs1;
    bus.in_rs2     = rs2;
    bus.in_use_rs2 = use2;
    bus.in_rd      = rd;
    bus.in_wr      = wr;
    bus.in_op      = op;
    #1;
  endtask

  task automatic wb(input logic v, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    bus.wb_valid = v;
    bus.wb_addr  = addr;
    bus.wb_data  = data;
    #1;
  endtask

  initial begin
    for (int i = 0; i < NREG; i++) rf_mem[i] = '0;
    bus.in_valid = 0; bus.in_rs1 = 0; bus.in_rs2 = 0; bus.in_use_rs2 = 0;
    bus.in_rd = 0; bus.in_wr = 0; bus.in_op = 0;
    bus.wb_valid = 0; bus.wb_addr = 0; bus.wb_data = 0; bus.out_ready = 1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_in_ready", 32'(bus.in_ready), 1);
    check("rst_out_a", 32'(bus.out_a), 0);

    // Preload r1/r2 through writeback to idle registers: busy must stay clear.
    wb(1, 1, 8'h05);
    check("rf_wen_pass", 32'(bus.rf_wen), 1);
    step();
    wb(1, 2, 8'h0A);
    step();
    wb(0, 0, 0);
    check("preload_busy", 32'(dut.u_sb.r_busy), 0);
    bus.in_rs1 = 1; bus.in_rs2 = 2; #1;
    check("raddr1_track", 32'(bus.rf_raddr1), 1);
    check("rdata1_r1", 32'(bus.rf_rdata1), 32'h05);

    // Basic fetch.
    issue(1, 2, 1, 3, 1, 4'h2);
    check("basic_ready", 32'(bus.in_ready), 1);
    step();
    bus.in_valid = 0;
    check("basic_valid", 32'(bus.out_valid), 1);
    check("basic_a", 32'(bus.out_a), 32'h05);
    check("basic_b", 32'(bus.out_b), 32'h0A);
    check("basic_rd", 32'(bus.out_rd), 3);
    check("basic_wr", 32'(bus.out_wr), 1);
    check("basic_op", 32'(bus.out_op), 2);
    check("basic_busy", 32'(dut.u_sb.r_busy), 32'h08);

    // RAW on r3: stall three cycles, then accept with forwarded writeback.
    issue(3, 1, 1, 5, 1, 4'h4);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("raw_stall%0d", i), 32'(bus.in_ready), 0);
      step();
    end
    check("raw_drained", 32'(bus.out_valid), 0);
    wb(1, 3, 8'h0F);
    check("raw_fwd_ready", 32'(bus.in_ready), 1);
    step();
    bus.in_valid = 0;
    wb(0, 0, 0);
    check("raw_a_fwd", 32'(bus.out_a), 32'h0F);
    check("raw_b", 32'(bus.out_b), 32'h05);
    check("raw_rd", 32'(bus.out_rd), 5);
    check("raw_busy", 32'(dut.u_sb.r_busy), 32'h20);
    bus.in_rs1 = 3; #1;
    check("rf_r3_written", 32'(bus.rf_rdata1), 32'h0F);

    // Backpressure: bundle for rd=5 must hold while the next one waits.
    bus.out_ready = 0;
    issue(1, 2, 1, 6, 1, 4'h7);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("bp_ready%0d", i), 32'(bus.in_ready), 0);
      check($sformatf("bp_valid%0d", i), 32'(bus.out_valid), 1);
      check($sformatf("bp_a%0d", i), 32'(bus.out_a), 32'h0F);
      check($sformatf("bp_rd%0d", i), 32'(bus.out_rd), 5);
      step();
    end
    bus.out_ready = 1; #1;
    check("bp_release_ready", 32'(bus.in_ready), 1);
    step();
    bus.in_valid = 0; #1;
    check("bp_next_valid", 32'(bus.out_valid), 1);
    check("bp_next_rd", 32'(bus.out_rd), 6);
    check("bp_next_a", 32'(bus.out_a), 32'h05);
    check("bp_next_b", 32'(bus.out_b), 32'h0A);
    check("bp_next_op", 32'(bus.out_op), 7);
    step();
    check("bp_no_dup", 32'(bus.out_valid), 0);
    check("bp_busy", 32'(dut.u_sb.r_busy), 32'h60);

    // WAW on r4, released by a same-cycle writeback that must not drop the new busy bit.
    issue(0, 0, 0, 4, 1, 4'h1);
    step();
    issue(1, 0, 0, 4, 1, 4'h3);
    check("waw_stall", 32'(bus.in_ready), 0);
    step();
    check("waw_stall2", 32'(bus.in_ready), 0);
    wb(1, 4, 8'h44);
    check("waw_clr_ready", 32'(bus.in_ready), 1);
    step();
    bus.in_valid = 0;
    wb(0, 0, 0);
    check("waw_rd", 32'(bus.out_rd), 4);
    check("waw_op", 32'(bus.out_op), 3);
    check("waw_b_zero", 32'(bus.out_b), 0);
    check("waw_busy_kept", 32'(dut.u_sb.r_busy), 32'h70);

    // rs2 busy but unused: no stall and operand B reads as zero.
    issue(2, 5, 0, 7, 0, 4'h9);
    check("nouse_ready", 32'(bus.in_ready), 1);
    step();
    bus.in_valid = 0; #1;
    check("nouse_a", 32'(bus.out_a), 32'h0A);
    check("nouse_b", 32'(bus.out_b), 0);
    check("nouse_wr", 32'(bus.out_wr), 0);

    // Asynchronous reset mid-cycle with a bundle in flight and busy bits set.
    bus.out_ready = 0;
    issue(1, 2, 1, 0, 1, 4'hA);
    step();
    check("pre_rst_valid", 32'(bus.out_valid), 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(bus.out_valid), 0);
    check("async_rst_busy", 32'(dut.u_sb.r_busy), 0);
    check("async_rst_op", 32'(bus.out_op), 0);
    step();
    rst = 1'b0;
    issue(5, 6, 1, 4, 1, 4'h0);
    check("post_rst_ready", 32'(bus.in_ready), 1);
    bus.in_valid = 0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
